// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared constants, FSM state encoding and the default line fill pattern for
// the backing-memory line responder.
//   LINE_BITS   : line width in bits (one 64-byte block)
//   OFFSET_BITS : byte-offset bits dropped from a request address
//   state_e     : responder FSM states
//   fillPattern : contents returned for a line that has never been written
// ---------------------------------------------------------------------------
package mem_resp_pkg;

    localparam int LINE_BITS   = 512;
    localparam int OFFSET_BITS = 6;
    localparam int ADDR_BITS   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // An unwritten line reads back as its own line address repeated across
    // the whole line, so a bench can tell which line it actually got.
    function automatic logic [LINE_BITS-1:0] fillPattern(input logic [ADDR_BITS-1:0] lineAddr);
        return {16{lineAddr}};
    endfunction

endpackage

// File: rtl/mem_line_store.sv
// ---------------------------------------------------------------------------
// mem_line_store
// Line array with one valid bit per line.
//   clk    : clock, rising edge
//   rst    : synchronous active-low reset; clears every valid bit
//   we     : write enable, stores wdata at waddr and marks that line valid
//   waddr  : write line index
//   wdata  : write line data
//   raddr  : read line index
//   rdata  : combinational read data (meaningful only when rvalid)
//   rvalid : combinational valid flag of the addressed line
// ---------------------------------------------------------------------------
module mem_line_store #(
    parameter int LINE_BITS   = 512,
    parameter int DEPTH_LINES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [$clog2(DEPTH_LINES)-1:0] waddr,
    input  logic [LINE_BITS-1:0]           wdata,
    input  logic [$clog2(DEPTH_LINES)-1:0] raddr,
    output logic [LINE_BITS-1:0]           rdata,
    output logic                           rvalid
);
    import mem_resp_pkg::*;

    logic [LINE_BITS-1:0]   mem [DEPTH_LINES];
    logic [DEPTH_LINES-1:0] valid_q;

    // Valid bits are the only state that reset touches; the data array keeps
    // whatever it held, and a cleared valid bit hides it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[waddr] <= 1'b1;
        end
    end

    // Data array has no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata  = mem[raddr];
    assign rvalid = valid_q[raddr];

endmodule

// File: rtl/mem_line_responder.sv
// ---------------------------------------------------------------------------
// mem_line_responder
// Backing-memory responder for cache line fills and dirty-line writebacks.
// Accepts one line request at a time and answers LATENCY cycles later.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   req_valid  : request present
//   req_ready  : responder idle and able to accept
//   req_write  : 1 = writeback, 0 = line fill
//   req_addr   : byte address, offset bits ignored, upper bits alias
//   req_wdata  : writeback line data
//   resp_valid : response present, held until resp_ready
//   resp_ready : cache accepts the response
//   resp_write : echo of req_write for the current response
//   resp_rdata : fill data, or the data just written for a writeback
//   busy       : responder not idle
//   rd_count   : accepted reads, saturating
//   wr_count   : accepted writes, saturating
// ---------------------------------------------------------------------------
module mem_line_responder #(
    parameter int LINE_BITS   = 512,
    parameter int OFFSET_BITS = 6,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_write,
    output logic [LINE_BITS-1:0] resp_rdata,
    output logic                 busy,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);
    import mem_resp_pkg::*;

    localparam int          IDX_W    = $clog2(DEPTH_LINES);
    localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);
    localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFFSET_BITS) - 64'd1);

    state_e state_q, state_d;

    logic [7:0]           cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic [IDX_W-1:0]     lineIdx_q, lineIdx_d;
    logic [31:0]          lineAddr_q, lineAddr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic                 respWrite_q, respWrite_d;
    logic [LINE_BITS-1:0] respRdata_q, respRdata_d;
    logic [15:0]          rdCount_q, rdCount_d;
    logic [15:0]          wrCount_q, wrCount_d;

    logic                 accept;
    logic                 finish;
    logic                 handshake;
    logic                 storeWe;
    logic [LINE_BITS-1:0] storeRdata;
    logic                 storeRvalid;

    assign accept    = req_valid && (state_q == IDLE);
    assign finish    = (state_q == WAIT) && (cnt_q == 8'd0);
    assign handshake = (state_q == RESP) && resp_ready;

    // Gating with rst means a writeback caught by reset in its commit cycle
    // never reaches the array.
    assign storeWe = rst && finish && write_q;

    mem_line_store #(
        .LINE_BITS  (LINE_BITS),
        .DEPTH_LINES(DEPTH_LINES)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (storeWe),
        .waddr (lineIdx_q),
        .wdata (wdata_q),
        .raddr (lineIdx_q),
        .rdata (storeRdata),
        .rvalid(storeRvalid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one transaction walks IDLE -> WAIT -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)     state_d = WAIT;
            WAIT:    if (cnt_q == 8'd0) state_d = RESP;
            RESP:    if (resp_ready)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; req_ready deliberately ignores req_valid.
    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        resp_valid = (state_q == RESP);
    end

    // Datapath next-state: request capture, latency countdown, memory action
    // on the last WAIT cycle and response clear on handshake.
    always_comb begin
        cnt_d       = cnt_q;
        write_d     = write_q;
        lineIdx_d   = lineIdx_q;
        lineAddr_d  = lineAddr_q;
        wdata_d     = wdata_q;
        respWrite_d = respWrite_q;
        respRdata_d = respRdata_q;
        rdCount_d   = rdCount_q;
        wrCount_d   = wrCount_q;

        if (accept) begin
            write_d    = req_write;
            lineIdx_d  = req_addr[OFFSET_BITS +: IDX_W];
            lineAddr_d = req_addr & ~OFF_MASK;
            wdata_d    = req_wdata;
            cnt_d      = CNT_LOAD;
            if (req_write) begin
                if (wrCount_q != 16'hFFFF) wrCount_d = wrCount_q + 16'd1;
            end else begin
                if (rdCount_q != 16'hFFFF) rdCount_d = rdCount_q + 16'd1;
            end
        end

        if ((state_q == WAIT) && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end

        if (finish) begin
            respWrite_d = write_q;
            if (write_q) begin
                respRdata_d = wdata_q;
            end else if (storeRvalid) begin
                respRdata_d = storeRdata;
            end else begin
                respRdata_d = LINE_BITS'(fillPattern(lineAddr_q));
            end
        end

        if (handshake) begin
            respRdata_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            write_q     <= 1'b0;
            lineIdx_q   <= '0;
            lineAddr_q  <= '0;
            wdata_q     <= '0;
            respWrite_q <= 1'b0;
            respRdata_q <= '0;
            rdCount_q   <= '0;
            wrCount_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            lineIdx_q   <= lineIdx_d;
            lineAddr_q  <= lineAddr_d;
            wdata_q     <= wdata_d;
            respWrite_q <= respWrite_d;
            respRdata_q <= respRdata_d;
            rdCount_q   <= rdCount_d;
            wrCount_q   <= wrCount_d;
        end
    end

    assign resp_write = respWrite_q;
    assign resp_rdata = respRdata_q;
    assign rd_count   = rdCount_q;
    assign wr_count   = wrCount_q;

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Backing-memory responder at the far end of the cache line-fill/writeback interface. Accepts one 512-bit line request at a time (read fill or dirty-line writeback) and answers after a fixed latency.
- Holds a line store with per-line valid bits. Unwritten lines return the deterministic pattern {16{line_addr}}.
- Sits below the cache controller and replaces its internal simulated memory data in system-level benches.

Parameters:
- LINE_BITS, 512, line width in bits (64-byte block).
- OFFSET_BITS, 6, byte-offset bits ignored in req_addr.
- DEPTH_LINES, 1024, number of stored lines; index = req_addr[OFFSET_BITS +: log2(DEPTH_LINES)]; upper address bits alias.
- LATENCY, 4, cycles from acceptance to resp_valid; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = writeback, 0 = line fill read.
- req_addr  in  32  byte address; offset bits ignored.
- req_wdata  in  LINE_BITS  writeback data.
- resp_valid  out  1  response present.
- resp_ready  in  1  cache accepts the response.
- resp_write  out  1  echo of req_write for the current response.
- resp_rdata  out  LINE_BITS  fill data; for writes, the data just written.
- busy  out  1  high in any state other than IDLE.
- rd_count  out  16  accepted reads, saturating at 16'hFFFF.
- wr_count  out  16  accepted writes, saturating at 16'hFFFF.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE.
  - All line valid bits clear; store contents are don't-care.
  - resp_valid=0, resp_write=0, resp_rdata=0, busy=0, rd_count=0, wr_count=0.
  - Reset mid-transaction discards the transaction with no response; a write not yet committed is lost.
- req_ready is a decode of state==IDLE and never depends on req_valid.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req_valid && req_ready, latch write, line index, line address (req_addr with the low OFFSET_BITS zeroed) and wdata.
  - Load cnt=LATENCY-1, increment the matching counter, go to WAIT.
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0, go to RESP at the next edge and, at that same edge, perform the memory action:
    - Write: store wdata, set valid, resp_rdata=wdata.
    - Read: resp_rdata = stored line if valid, else {16{line_addr}}.
  - Set resp_write and resp_valid=1 at that edge.
- Latency: a request accepted at edge k gives resp_valid=1 from edge k+LATENCY.
- RESP:
  - resp_valid, resp_write and resp_rdata stay stable until resp_valid && resp_ready.
  - At that edge go to IDLE, resp_valid=0, resp_rdata=0.
- Single outstanding transaction. Read-after-write to the same line always returns the written data.
- Minimum spacing between acceptances is LATENCY+2 cycles: 1 RESP handshake cycle plus 1 IDLE cycle.
- req_valid outside IDLE is ignored (no acceptance, no counting).
- resp_ready while resp_valid=0 has no effect.
- Address aliasing: addresses differing only above the index bits share one line. This is by design and not flagged.
- Counters saturate; they never wrap.

Decomposition:
- Package mem_resp_pkg:
  - LINE_BITS, OFFSET_BITS.
  - State encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
  - Function for the default fill pattern {16{line_addr}}.
- Sub-module mem_line_store holds the line array plus valid vector.
  - Synchronous write port; combinational read with valid flag.
  - Synchronous valid clear on rst.
- Top holds the FSM, latency counter, response registers and statistics counters.

Test Plan:
- Reset with rst=0 for 2 cycles, then read 32'h00002000 (LATENCY=4) → accepted at edge k; resp_valid at edge k+4; resp_rdata={16{32'h00002000}}; resp_write=0; rd_count=1.
- Write 32'h00001000 with data 512'hDEADBEEF, then read 32'h0000103C → read returns 512'hDEADBEEF (offset ignored); wr_count=1, rd_count=1.
- Hold resp_ready=0 for 5 cycles during RESP → resp_valid and resp_rdata stable for all 5 cycles; req_valid pulses in that window are not accepted and not counted; req_ready=0.
- Write 32'h00003000 (data 512'hABCDEF), then read 32'h00013000 (DEPTH_LINES=1024, aliases the same index) → returns 512'hABCDEF.
- Assert rst=0 while in WAIT after a write to 32'h00004000, release, then read 32'h00004000 → no response from the aborted transaction; read returns {16{32'h00004000}}; counters show rd_count=1, wr_count=0.
- LATENCY=1 back-to-back reads with resp_ready tied high → each resp_valid occurs 1 edge after acceptance; acceptances exactly 3 cycles apart.
